cmd_queue: RTL and testbench

Parametrised command merge-and-buffer stage between the input decoders (buttons, switches, UART, gravity timers) and the game state machine. It arbitrates up to N_CH request channels into one command per cycle and adds per-channel auto-repeat for held inputs (initial delay, then a fixed period). Commands are buffered in a show-ahead FIFO of configurable depth, with drop accounting and flush. The consumer pops with a valid/ready handshake whenever its FSM is idle.

---
 rtl/cmd_queue.sv | 148 ++++++++++++++
 tb/tb_cmd_queue.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_queue.sv
// Command merge-and-buffer stage: per-channel auto-repeat, fixed-priority arbitration
// and a show-ahead FIFO with drop accounting and flush.
module cmd_queue #(
    parameter int              N_CH      = 4,
    parameter int              CMD_W     = 4,
    parameter int              DEPTH     = 8,
    parameter int              DAS_TICK  = 16,
    parameter int              ARR_TICK  = 4,
    parameter logic [CMD_W-1:0] NONE_CODE = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           req_valid,
    input  logic [N_CH*CMD_W-1:0]     req_cmd,
    input  logic [N_CH-1:0]           req_hold,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [CMD_W-1:0]          out_cmd,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int MAX_T = (DAS_TICK > ARR_TICK) ? DAS_TICK : ARR_TICK;
    localparam int TW    = $clog2(MAX_T) + 1;
    localparam int NW    = $clog2(N_CH + 1);

    logic [TW-1:0]    rep_t_q   [N_CH];
    logic [CMD_W-1:0] rep_cmd_q [N_CH];
    logic [CMD_W-1:0] cand_cmd  [N_CH];
    logic [N_CH-1:0]  rep_req;
    logic [N_CH-1:0]  cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_rep
            // A fresh request in the same cycle suppresses this channel's repeat.
            assign rep_req[gi]  = req_hold[gi] && !req_valid[gi] && (rep_t_q[gi] == TW'(1));
            assign cand[gi]     = req_valid[gi] | rep_req[gi];
            assign cand_cmd[gi] = req_valid[gi] ? req_cmd[gi*CMD_W +: CMD_W] : rep_cmd_q[gi];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rep_t_q[gi]   <= '0;
                    rep_cmd_q[gi] <= NONE_CODE;
                end else if (flush) begin
                    rep_t_q[gi]   <= '0;
                end else if (req_valid[gi]) begin
                    rep_cmd_q[gi] <= req_cmd[gi*CMD_W +: CMD_W];
                    rep_t_q[gi]   <= TW'(DAS_TICK);
                end else if (req_hold[gi]) begin
                    if (rep_t_q[gi] == TW'(1)) begin
                        rep_t_q[gi] <= TW'(ARR_TICK);
                    end else if (rep_t_q[gi] != '0) begin
                        rep_t_q[gi] <= rep_t_q[gi] - TW'(1);
                    end
                end else begin
                    rep_t_q[gi]   <= '0;
                end
            end
        end
    endgenerate

    logic             win_valid;
    logic [CMD_W-1:0] win_cmd;
    logic [NW-1:0]    cand_num;
    logic [NW-1:0]    losers;

    // Ascending scan so the highest-index candidate is the last assignment.
    always_comb begin
        win_valid = 1'b0;
        win_cmd   = NONE_CODE;
        cand_num  = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (cand[c]) begin
                win_valid = 1'b1;
                win_cmd   = cand_cmd[c];
                cand_num  = cand_num + NW'(1);
            end
        end
        losers = win_valid ? (cand_num - NW'(1)) : '0;
    end

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_q, drop_d;
    logic             full, pop, push, discard;
    logic [16:0]      drop_sum;

    assign full    = (count_q == CW'(DEPTH));
    assign pop     = (count_q != '0) && out_ready && !flush;
    assign push    = win_valid && (!full || pop) && !flush;
    assign discard = win_valid && !push && !flush;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = 1'b0;
        drop_d     = drop_q;
        drop_sum   = {1'b0, drop_q} + 17'(losers) + 17'(discard);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d    = count_q + CW'(push) - CW'(pop);
            overflow_d = discard;
            drop_d     = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Storage carries no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= win_cmd;
    end

    assign out_valid = (count_q != '0);
    assign out_cmd   = out_valid ? mem_q[rd_ptr_q] : NONE_CODE;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed bench for cmd_queue: stimulus pushes expected codes into a scoreboard queue,
// a negedge monitor pops and compares on every accepted output.
module tb_cmd_queue;

    localparam int N_CH  = 4;
    localparam int CMD_W = 4;
    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       req_valid;
    logic [N_CH*CMD_W-1:0] req_cmd;
    logic [N_CH-1:0]       req_hold;
    logic                  flush;
    logic                  out_valid;
    logic [CMD_W-1:0]      out_cmd;
    logic                  out_ready;
    logic [2:0]            count;
    logic                  overflow;
    logic [15:0]           drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_drop = 0;
    logic [CMD_W-1:0] exp_q [$];

    cmd_queue #(
        .N_CH(N_CH), .CMD_W(CMD_W), .DEPTH(DEPTH),
        .DAS_TICK(5), .ARR_TICK(3), .NONE_CODE(4'd0)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_cmd(req_cmd),
        .req_hold(req_hold), .flush(flush), .out_valid(out_valid), .out_cmd(out_cmd),
        .out_ready(out_ready), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int ch, input int code);
        req_valid[ch] = 1'b1;
        req_cmd[ch*CMD_W +: CMD_W] = CMD_W'(code);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
    endtask

    task automatic run_repeat(input int hold_last);
        int cnt;
        bit exp_push;
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            req_valid = '0;
            if (k == 0) set_req(0, 7);
            req_hold[0] = (k <= hold_last);
            exp_push = (k == 0) || (k >= 5 && ((k - 5) % 3) == 0 && k <= hold_last);
            if (exp_push) begin
                exp_q.push_back(4'd7);
                cnt++;
            end
            step();
            chk($sformatf("repeat_h%0d_count_k%0d", hold_last, k), int'(count), cnt);
        end
        req_valid = '0;
        req_hold  = '0;
        drain(cnt);
        chk("repeat_drained", int'(count), 0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [CMD_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got %0d, required no output", out_cmd);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out_cmd", int'(out_cmd), int'(e));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ec;
        bit pop;
        reset = 1'b1; req_valid = '0; req_cmd = '0; req_hold = '0; flush = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_cmd",   int'(out_cmd),   0);
        chk("rst_count",     int'(count),     0);
        chk("rst_overflow",  int'(overflow),  0);
        chk("rst_drop",      int'(drop_cnt),  0);
        reset = 1'b0;
        step();

        // Priority: ch3 wins over ch1, ch1 is a dropped loser
        req_valid = '0;
        set_req(1, 2);
        set_req(3, 5);
        exp_q.push_back(4'd5);
        step();
        req_valid = '0;
        exp_drop = 1;
        chk("prio_count",    int'(count),    1);
        chk("prio_out_cmd",  int'(out_cmd),  5);
        chk("prio_drop",     int'(drop_cnt), exp_drop);
        chk("prio_overflow", int'(overflow), 0);
        drain(1);
        chk("prio_empty_cmd", int'(out_cmd), 0);

        // Auto-repeat, hold through offset 11 then released at offset 10
        run_repeat(11);
        run_repeat(9);

        // Full handling
        for (int i = 1; i <= 5; i++) begin
            req_valid = '0;
            set_req(0, i);
            if (i <= 4) exp_q.push_back(CMD_W'(i));
            step();
            chk($sformatf("full_overflow_%0d", i), int'(overflow), (i == 5) ? 1 : 0);
        end
        req_valid = '0;
        exp_drop = 2;
        chk("full_count",   int'(count),    4);
        chk("full_drop",    int'(drop_cnt), exp_drop);
        chk("full_out_cmd", int'(out_cmd),  1);
        step();
        chk("full_ovf_pulse_end", int'(overflow), 0);
        set_req(0, 6);
        out_ready = 1'b1;
        exp_q.push_back(4'd6);
        step();
        req_valid = '0;
        out_ready = 1'b0;
        chk("fullpop_count",    int'(count),    4);
        chk("fullpop_overflow", int'(overflow), 0);
        chk("fullpop_drop",     int'(drop_cnt), exp_drop);
        chk("fullpop_out_cmd",  int'(out_cmd),  2);
        drain(4);
        chk("full_drain_valid", int'(out_valid), 0);
        chk("full_drain_cmd",   int'(out_cmd),   0);

        // Ordering and wrap-around
        ec = 0;
        for (int i = 1; i <= 10; i++) begin
            req_valid = '0;
            set_req(0, i);
            out_ready = (i > 2);
            exp_q.push_back(CMD_W'(i));
            pop = (ec > 0) && out_ready;
            step();
            ec = ec + 1 - int'(pop);
            chk($sformatf("wrap_count_%0d", i), int'(count), ec);
            chk($sformatf("wrap_le4_%0d", i), int'(count <= 3'd4), 1);
        end
        req_valid = '0;
        out_ready = 1'b1;
        for (int j = 0; j < 8 && ec > 0; j++) begin
            step();
            ec--;
        end
        out_ready = 1'b0;
        chk("wrap_drained_cmd",   int'(out_cmd), 0);
        chk("wrap_drained_count", int'(count),   0);

        // Flush with push and pop pending, ch1 held so a repeat would follow
        req_hold[1] = 1'b1;
        set_req(1, 9);
        exp_q.push_back(4'd9);
        step();
        req_valid = '0;
        set_req(0, 2);
        exp_q.push_back(4'd2);
        step();
        set_req(0, 3);
        exp_q.push_back(4'd3);
        step();
        chk("flush_pre_count", int'(count), 3);
        set_req(0, 4);
        flush = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        req_valid = '0;
        out_ready = 1'b0;
        exp_q.delete();
        chk("flush_count", int'(count),     0);
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_drop",  int'(drop_cnt),  exp_drop);
        chk("flush_cmd",   int'(out_cmd),   0);
        repeat (10) step();
        chk("flush_no_repeat", int'(count), 0);
        req_hold = '0;

        // Asynchronous reset at count=2, drop_cnt=3
        set_req(0, 1);
        set_req(1, 2);
        exp_q.push_back(4'd2);
        step();
        req_valid = '0;
        set_req(0, 3);
        exp_q.push_back(4'd3);
        step();
        req_valid = '0;
        exp_drop = 3;
        chk("arst_pre_count", int'(count),    2);
        chk("arst_pre_drop",  int'(drop_cnt), exp_drop);
        #3;
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_drop = 0;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_out_cmd",   int'(out_cmd),   0);
        chk("arst_count",     int'(count),     0);
        chk("arst_overflow",  int'(overflow),  0);
        chk("arst_drop",      int'(drop_cnt),  0);
        #2;
        reset = 1'b0;
        set_req(0, 6);
        exp_q.push_back(4'd6);
        step();
        req_valid = '0;
        chk("arst_post_count", int'(count),   1);
        chk("arst_post_cmd",   int'(out_cmd), 6);
        drain(1);
        chk("arst_post_drained", int'(out_cmd), 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
